// File: rtl/color_pkg.sv
// Shared types and codes for the color FSM and its command driver.
// Holds the color/state enums and the FSM command and output encodings.
package color_pkg;

    typedef enum logic {
        BLUE = 1'b0,
        RED  = 1'b1
    } color_state_t;

    localparam logic [1:0] CMD_HOLD   = 2'h0;
    localparam logic [1:0] CMD_TOGGLE = 2'h1;

    localparam logic [1:0] OUT_BLUE = 2'h1;
    localparam logic [1:0] OUT_RED  = 2'h2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_DWELL,
        ST_RESP
    } steer_state_t;

endpackage

// File: rtl/color_steer_if.sv
// Request/response handshake bundle between a requester and color_steer.
// master: requester side (req_valid/req_color/req_dwell/rsp_ready out);
// slave: color_steer side (req_ready/rsp_valid/rsp_err out).
interface color_steer_if #(
    parameter int DWELL_WIDTH = 4
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_color;
    logic [DWELL_WIDTH-1:0] req_dwell;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_err;

    modport master (
        output req_valid,
        output req_color,
        output req_dwell,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_color,
        input  req_dwell,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_err
    );

endinterface

// File: rtl/color_out_decode.sv
// Combinational decoder for the color FSM's Mealy output word.
// Ports: code (fsm out word) -> legal (1/2 only), color (next state).
module color_out_decode
    import color_pkg::*;
(
    input  logic [1:0]   code,
    output logic         legal,
    output color_state_t color
);

    always_comb begin
        legal = 1'b0;
        color = BLUE;
        unique case (1'b1)
            (code == OUT_BLUE): begin
                legal = 1'b1;
                color = BLUE;
            end
            (code == OUT_RED): begin
                legal = 1'b1;
                color = RED;
            end
            default: begin
                legal = 1'b0;
                color = BLUE;
            end
        endcase
    end

endmodule

// File: rtl/color_steer.sv
// Command driver steering the two-state color FSM to a target color,
// holding it for a dwell time and returning a response with an error flag.
// Ports: clk, rst (sync, active-high), bus (color_steer_if.slave),
// fsm_in (command to FSM), fsm_out (FSM Mealy output), cur_color.
// Build option: COLOR_STEER_CHECK_EN enables closed-loop checking of
// fsm_out; without it fsm_out is ignored and rsp_err stays 0.
module color_steer
    import color_pkg::*;
#(
    parameter int DWELL_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    color_steer_if.slave        bus,
    output logic [1:0]          fsm_in,
    input  logic [1:0]          fsm_out,
    output logic                cur_color
);

    steer_state_t           state;
    color_state_t           target;
    color_state_t           cur_q;
    logic [DWELL_WIDTH-1:0] dwell;
    logic [DWELL_WIDTH-1:0] cnt;
    logic                   err;
    logic                   req_ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;

    logic         dec_legal;
    color_state_t dec_color;

    // obs_bad: observed word disagrees with target
    // obs_load/obs_color: whether and what to copy into cur_color
    logic         obs_bad;
    logic         obs_load;
    color_state_t obs_color;

    color_out_decode u_dec (
        .code  (fsm_out),
        .legal (dec_legal),
        .color (dec_color)
    );

`ifdef COLOR_STEER_CHECK_EN
    assign obs_bad   = !dec_legal || (dec_color != target);
    assign obs_load  = dec_legal;
    assign obs_color = dec_color;
`else
    logic unused_dec;
    assign unused_dec = dec_legal ^ dec_color;
    assign obs_bad    = 1'b0;
    assign obs_load   = 1'b1;
    assign obs_color  = target;
`endif

    assign fsm_in = (state == ST_DRIVE && cur_q != target)
                  ? CMD_TOGGLE : CMD_HOLD;

    assign cur_color     = cur_q;
    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            target      <= RED;
            cur_q       <= RED;
            dwell       <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        target      <= color_state_t'(bus.req_color);
                        dwell       <= bus.req_dwell;
                        err         <= 1'b0;
                        req_ready_q <= 1'b0;
                        state       <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (obs_load)
                        cur_q <= obs_color;
                    err <= obs_bad;
                    cnt <= dwell;
                    if (dwell != '0) begin
                        state <= ST_DWELL;
                    end else begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= obs_bad;
                    end
                end
                ST_DWELL: begin
                    if (obs_load)
                        cur_q <= obs_color;
                    err <= err | obs_bad;
                    cnt <= cnt - DWELL_WIDTH'(1);
                    if (cnt == DWELL_WIDTH'(1)) begin
                        state       <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err | obs_bad;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
